// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad key reader.
//   DefFifoDepth : default number of buffered key codes
//   StIdle/StAck : handshake FSM state encoding
//   KeyMap       : 16-entry {row,col} -> key code table, nibble i holds code for index i
//   decode_key() : combinational lookup into KeyMap
package keypad_pkg;

  localparam int unsigned DefFifoDepth = 4;

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StAck  = 1'b1;

  // Rows from the top of the keypad: 1 2 3 A / 4 5 6 B / 7 8 9 C / E 0 F D.
  localparam logic [63:0] KeyMap = {4'hD, 4'hF, 4'h0, 4'hE,
                                    4'hC, 4'h9, 4'h8, 4'h7,
                                    4'hB, 4'h6, 4'h5, 4'h4,
                                    4'hA, 4'h3, 4'h2, 4'h1};

  function automatic logic [3:0] decode_key(input logic [3:0] row_col);
    logic [5:0] base;
    base = {row_col, 2'b00};
    return KeyMap[base +: 4];
  endfunction

endpackage

// File: rtl/keypad_key_fifo.sv
// Small key-code FIFO with registered occupancy.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write a code (ignored when full or clearing)
//   pop_i         : remove head (ignored when empty or clearing)
//   clear_i       : synchronous flush, overrides push and pop
//   count_o       : occupancy; full_o/valid_o derived from it
//   head_o        : code at head, 0 when empty
module keypad_key_fifo #(
  parameter int unsigned Depth = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [3:0] data_i,
  input  logic       pop_i,
  input  logic       clear_i,
  output logic [4:0] count_o,
  output logic       full_o,
  output logic       valid_o,
  output logic [3:0] head_o
);

  localparam int unsigned PtrW = $clog2(Depth);

  logic [3:0]      mem_q [Depth];
  logic [PtrW-1:0] wptr_q, wptr_d;
  logic [PtrW-1:0] rptr_q, rptr_d;
  logic [4:0]      count_q, count_d;
  logic            do_push, do_pop;

  // Full and empty are judged on registered occupancy only.
  assign full_o  = (count_q == 5'(Depth));
  assign valid_o = (count_q != 5'd0);
  assign do_push = push_i & ~full_o & ~clear_i;
  assign do_pop  = pop_i & valid_o & ~clear_i;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      // Depth is a power of two, so natural overflow gives the modulo wrap.
      if (do_push) wptr_d = wptr_q + PtrW'(1);
      if (do_pop)  rptr_d = rptr_q + PtrW'(1);
      if (do_push && !do_pop)      count_d = count_q + 5'd1;
      else if (!do_push && do_pop) count_d = count_q - 5'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: head is masked while the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

  assign head_o  = valid_o ? mem_q[rptr_q] : 4'h0;
  assign count_o = count_q;

endmodule

// File: rtl/keypad_key_reader.sv
// Keypad key reader: handshakes with a key scanner, decodes {row,col} into a key
// code and buffers codes in a FIFO for a downstream consumer.
//   Clock, Reset   : rising-edge clock, asynchronous active-low reset
//   KeyRdy         : scanner presents a key on RowColVector ([3:2] row, [1:0] col)
//   KeyRd          : registered acknowledge, held until KeyRdy drops
//   KeyValid       : FIFO non-empty, KeyCode holds the head code (0 otherwise)
//   KeyAccept      : pop head when KeyValid=1
//   Clear          : synchronous FIFO flush, handshake unaffected
//   KeyCount       : FIFO occupancy
module keypad_key_reader
  import keypad_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       KeyRdy,
  input  logic [3:0] RowColVector,
  output logic       KeyRd,
  output logic       KeyValid,
  output logic [3:0] KeyCode,
  input  logic       KeyAccept,
  input  logic       Clear,
  output logic [4:0] KeyCount
);

  logic [0:0] state_q, state_d;
  logic       key_rd_q, key_rd_d;
  logic       push;
  logic       fifo_full;

  // A full FIFO leaves the FSM in idle with KeyRd low, so the scanner stalls
  // and the key is taken once space frees up.
  always_comb begin
    state_d  = state_q;
    key_rd_d = key_rd_q;
    push     = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (KeyRdy && !fifo_full) begin
          push     = 1'b1;
          state_d  = StAck;
          key_rd_d = 1'b1;
        end
      end
      StAck: begin
        if (!KeyRdy) begin
          state_d  = StIdle;
          key_rd_d = 1'b0;
        end
      end
      default: begin
        state_d  = StIdle;
        key_rd_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= StIdle;
      key_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      key_rd_q <= key_rd_d;
    end
  end

  keypad_key_fifo #(
    .Depth(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (Clock),
    .rst_ni (Reset),
    .push_i (push),
    .data_i (decode_key(RowColVector)),
    .pop_i  (KeyAccept),
    .clear_i(Clear),
    .count_o(KeyCount),
    .full_o (fifo_full),
    .valid_o(KeyValid),
    .head_o (KeyCode)
  );

  assign KeyRd = key_rd_q;

endmodule

// File: tb/tb_keypad_key_reader.sv
module tb_keypad_key_reader;

  logic       clock = 1'b0;
  logic       reset;
  logic       key_rdy;
  logic [3:0] row_col;
  logic       key_rd;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_accept;
  logic       clear;
  logic [4:0] key_count;

  int tests = 0;
  int fails = 0;
  logic [3:0] sb[$];

  keypad_key_reader #(
    .FIFO_DEPTH(4)
  ) dut (
    .Clock       (clock),
    .Reset       (reset),
    .KeyRdy      (key_rdy),
    .RowColVector(row_col),
    .KeyRd       (key_rd),
    .KeyValid    (key_valid),
    .KeyCode     (key_code),
    .KeyAccept   (key_accept),
    .Clear       (clear),
    .KeyCount    (key_count)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  // Compare head against the scoreboard, then pop it with one accept cycle.
  task automatic pop_one(input string tag);
    logic [3:0] exp;
    check({tag, "_valid"}, 8'(key_valid), 8'h1);
    check({tag, "_sb"}, 8'(sb.size() != 0), 8'h1);
    if (sb.size() != 0) begin
      exp = sb.pop_front();
      check({tag, "_code"}, 8'(key_code), 8'(exp));
    end
    key_accept = 1'b1;
    tick();
    key_accept = 1'b0;
  endtask

  // Full handshake for one key that is expected to be accepted immediately.
  task automatic press(input string tag, input logic [3:0] rc, input logic [3:0] code);
    row_col = rc;
    key_rdy = 1'b1;
    sb.push_back(code);
    tick();
    check({tag, "_rd_hi"}, 8'(key_rd), 8'h1);
    key_rdy = 1'b0;
    tick();
    check({tag, "_rd_lo"}, 8'(key_rd), 8'h0);
  endtask

  initial begin
    logic [3:0] rcs [6];
    logic [3:0] codes [6];
    logic [3:0] exp;
    rcs   = '{4'b1010, 4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b1111};
    codes = '{4'h9, 4'hC, 4'hE, 4'h0, 4'hF, 4'hD};

    reset      = 1'b0;
    key_rdy    = 1'b0;
    row_col    = 4'h0;
    key_accept = 1'b0;
    clear      = 1'b0;
    #3;
    check("rst_rd", 8'(key_rd), 8'h0);
    check("rst_valid", 8'(key_valid), 8'h0);
    check("rst_code", 8'(key_code), 8'h0);
    check("rst_count", 8'(key_count), 8'h0);
    @(negedge clock);
    reset = 1'b1;
    tick();

    // Single key: row1,col2 -> 6
    row_col = 4'b0110;
    key_rdy = 1'b1;
    sb.push_back(4'h6);
    tick();
    check("k6_rd", 8'(key_rd), 8'h1);
    check("k6_valid", 8'(key_valid), 8'h1);
    check("k6_code", 8'(key_code), 8'h6);
    check("k6_count", 8'(key_count), 8'h1);
    key_rdy = 1'b0;
    tick();
    check("k6_rd_lo", 8'(key_rd), 8'h0);
    pop_one("k6_pop");
    check("k6_empty_count", 8'(key_count), 8'h0);
    check("k6_empty_code", 8'(key_code), 8'h0);

    // Accept while empty is ignored
    key_accept = 1'b1;
    tick();
    key_accept = 1'b0;
    check("empty_pop_count", 8'(key_count), 8'h0);
    check("empty_pop_valid", 8'(key_valid), 8'h0);

    // Fill to full, fifth key back-pressured
    press("f1", 4'b0000, 4'h1);
    press("f2", 4'b0001, 4'h2);
    press("f3", 4'b0010, 4'h3);
    press("fA", 4'b0011, 4'hA);
    check("full_count", 8'(key_count), 8'h4);
    row_col = 4'b0100;
    key_rdy = 1'b1;
    sb.push_back(4'h4);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_rd", 8'(key_rd), 8'h0);
      check("bp_count", 8'(key_count), 8'h4);
    end
    // Pop in the same edge must not let the waiting key in yet
    pop_one("bp_pop");
    check("bp_after_pop_rd", 8'(key_rd), 8'h0);
    check("bp_after_pop_count", 8'(key_count), 8'h3);
    check("bp_after_pop_code", 8'(key_code), 8'h2);
    tick();
    check("bp_ack_rd", 8'(key_rd), 8'h1);
    check("bp_ack_count", 8'(key_count), 8'h4);
    key_rdy = 1'b0;
    tick();
    check("bp_rd_lo", 8'(key_rd), 8'h0);
    for (int i = 0; i < 4; i++) pop_one("drain");
    check("drain_count", 8'(key_count), 8'h0);

    // KeyRdy held long: exactly one push
    row_col = 4'b0101;
    key_rdy = 1'b1;
    sb.push_back(4'h5);
    tick();
    check("hold_rd", 8'(key_rd), 8'h1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_rd_stay", 8'(key_rd), 8'h1);
      check("hold_count", 8'(key_count), 8'h1);
    end
    key_rdy = 1'b0;
    tick();
    check("hold_rd_lo", 8'(key_rd), 8'h0);
    check("hold_count_end", 8'(key_count), 8'h1);
    pop_one("hold_pop");

    // Two buffered codes, then six simultaneous push+pop across pointer wrap
    press("w7", 4'b1000, 4'h7);
    press("w8", 4'b1001, 4'h8);
    for (int i = 0; i < 6; i++) begin
      row_col    = rcs[i];
      key_rdy    = 1'b1;
      key_accept = 1'b1;
      check("pp_valid", 8'(key_valid), 8'h1);
      exp = sb.pop_front();
      check("pp_code", 8'(key_code), 8'(exp));
      sb.push_back(codes[i]);
      tick();
      check("pp_count", 8'(key_count), 8'h2);
      check("pp_rd", 8'(key_rd), 8'h1);
      key_rdy    = 1'b0;
      key_accept = 1'b0;
      tick();
      check("pp_rd_lo", 8'(key_rd), 8'h0);
    end
    pop_one("pp_tail0");
    pop_one("pp_tail1");
    check("pp_empty", 8'(key_count), 8'h0);

    // Clear with simultaneous push
    press("c2", 4'b0001, 4'h2);
    row_col = 4'b0000;
    key_rdy = 1'b1;
    clear   = 1'b1;
    tick();
    sb.delete();
    clear = 1'b0;
    check("clr_count", 8'(key_count), 8'h0);
    check("clr_valid", 8'(key_valid), 8'h0);
    check("clr_code", 8'(key_code), 8'h0);
    check("clr_rd", 8'(key_rd), 8'h1);
    key_rdy = 1'b0;
    tick();
    check("clr_rd_lo", 8'(key_rd), 8'h0);
    check("clr_count_end", 8'(key_count), 8'h0);

    // Reset during ACK
    row_col = 4'b0111;
    key_rdy = 1'b1;
    tick();
    check("ra_rd", 8'(key_rd), 8'h1);
    check("ra_count", 8'(key_count), 8'h1);
    #2;
    reset = 1'b0;
    #1;
    sb.delete();
    check("ra_async_rd", 8'(key_rd), 8'h0);
    check("ra_async_count", 8'(key_count), 8'h0);
    check("ra_async_valid", 8'(key_valid), 8'h0);
    check("ra_async_code", 8'(key_code), 8'h0);
    #2;
    reset = 1'b1;
    sb.push_back(4'hB);
    tick();
    check("ra_new_rd", 8'(key_rd), 8'h1);
    check("ra_new_count", 8'(key_count), 8'h1);
    key_rdy = 1'b0;
    tick();
    check("ra_rd_lo", 8'(key_rd), 8'h0);
    pop_one("ra_pop");
    check("ra_end_count", 8'(key_count), 8'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
